// File: rtl/mon_cmd_parser_pkg.sv
// Shared monitor definitions: ASCII control constants, parser FSM states and
// small character-class helpers.
package mon_cmd_parser_pkg;

   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_ESC = 8'h1B;
   localparam logic [7:0] ASCII_SP  = 8'h20;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_ECHO,
      S_LF,
      S_PARSE,
      S_EXEC
   } parser_state_t;

   function automatic logic is_alpha(input logic [7:0] c);
      return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
   endfunction

   // Clearing bit 5 folds a-z onto A-Z; only ever applied to letters.
   function automatic logic [7:0] to_upper(input logic [7:0] c);
      return c & 8'hDF;
   endfunction

endpackage

// File: rtl/mon_hex_nibble.sv
// Combinational ASCII hex digit decoder: flags 0-9/a-f/A-F and returns the
// 4-bit value of the digit.
module mon_hex_nibble (
   input  logic [7:0] ch,
   output logic       is_hex,
   output logic [3:0] nibble
);

   always_comb begin
      is_hex = 1'b0;
      nibble = '0;
      if ((ch >= 8'h30) && (ch <= 8'h39)) begin
         is_hex = 1'b1;
         nibble = ch[3:0];
      end else if (((ch >= 8'h41) && (ch <= 8'h46)) || ((ch >= 8'h61) && (ch <= 8'h66))) begin
         is_hex = 1'b1;
         nibble = ch[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/mon_cmd_parser.sv
// Monitor command-line front end: drains the UART rx FIFO, echoes to tx and
// parses "<C> [hex0] [hex1]<CR>" into a held command for the monitor core.
module mon_cmd_parser
   import mon_cmd_parser_pkg::*;
#(
   parameter int unsigned ECHO_EN = 1,
   parameter int unsigned ARG_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_fifo_dvalid,
   input  logic [7:0]       rx_rdata,
   output logic             rx_rden,
   input  logic             tx_fifo_full,
   output logic [7:0]       tx_wdata,
   output logic             tx_wten,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [7:0]       cmd_code,
   output logic [1:0]       cmd_argc,
   output logic [ARG_W-1:0] cmd_arg0,
   output logic [ARG_W-1:0] cmd_arg1,
   output logic             parse_err
);

   parser_state_t state, state_nxt;

   logic [7:0]       ch;
   logic [7:0]       code;
   logic [1:0]       argc;
   logic [ARG_W-1:0] arg0, arg1;
   logic             field_open;
   logic             err;

   logic             ch_is_hex;
   logic [3:0]       ch_nibble;
   logic             line_clr;
   logic             sel_arg1;

   mon_hex_nibble u_hex (
      .ch     (ch),
      .is_hex (ch_is_hex),
      .nibble (ch_nibble)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         ch    <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_READ)
            ch <= rx_rdata;
      end
   end

   always_comb begin
      state_nxt = state;
      rx_rden   = 1'b0;
      tx_wten   = 1'b0;
      tx_wdata  = '0;
      cmd_valid = 1'b0;
      parse_err = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_fifo_dvalid)
               state_nxt = S_READ;
         end
         S_READ: begin
            rx_rden   = 1'b1;
            state_nxt = S_ECHO;
         end
         S_ECHO: begin
            if (ECHO_EN == 0) begin
               state_nxt = S_PARSE;
            end else if (!tx_fifo_full) begin
               tx_wten   = 1'b1;
               tx_wdata  = ch;
               state_nxt = (ch == ASCII_CR) ? S_LF : S_PARSE;
            end
         end
         S_LF: begin
            if (!tx_fifo_full) begin
               tx_wten   = 1'b1;
               tx_wdata  = ASCII_LF;
               state_nxt = S_PARSE;
            end
         end
         S_PARSE: begin
            state_nxt = S_IDLE;
            if (ch == ASCII_CR) begin
               if (err)
                  parse_err = 1'b1;
               else if (code != '0)
                  state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            cmd_valid = 1'b1;
            if (cmd_ready)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Line state is wiped on abort, on a CR that issues nothing, and on handoff.
   assign line_clr = ((state == S_PARSE) &&
                      ((ch == ASCII_ESC) || ((ch == ASCII_CR) && (err || (code == '0))))) ||
                     ((state == S_EXEC) && cmd_ready);

   // Digit lands in the open field, or in the field about to be opened.
   assign sel_arg1 = field_open ? (argc == 2'd2) : (argc == 2'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code       <= '0;
         argc       <= '0;
         arg0       <= '0;
         arg1       <= '0;
         field_open <= 1'b0;
         err        <= 1'b0;
      end else if (line_clr) begin
         code       <= '0;
         argc       <= '0;
         arg0       <= '0;
         arg1       <= '0;
         field_open <= 1'b0;
         err        <= 1'b0;
      end else if (state == S_PARSE) begin
         if (ch == ASCII_SP) begin
            field_open <= 1'b0;
         end else if (ch == ASCII_LF || ch == ASCII_CR) begin
            // LF ignored; CR with a command is held until handoff
         end else if ((code == '0) && is_alpha(ch)) begin
            code <= to_upper(ch);
         end else if ((code != '0) && ch_is_hex) begin
            if (!field_open && (argc == 2'd2)) begin
               err <= 1'b1;
            end else begin
               if (!field_open) begin
                  argc       <= argc + 2'd1;
                  field_open <= 1'b1;
               end
               if (sel_arg1)
                  arg1 <= {arg1[ARG_W-5:0], ch_nibble};
               else
                  arg0 <= {arg0[ARG_W-5:0], ch_nibble};
            end
         end else begin
            err <= 1'b1;
         end
      end
   end

   assign cmd_code = code;
   assign cmd_argc = argc;
   assign cmd_arg0 = arg0;
   assign cmd_arg1 = arg1;

endmodule

// File: tb/tb_mon_cmd_parser.sv
// Directed self-checking bench for mon_cmd_parser with a behavioural rx FIFO
// and a tx capture log.
module tb_mon_cmd_parser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_fifo_dvalid;
   logic [7:0]  rx_rdata;
   logic        rx_rden;
   logic        tx_fifo_full = 1'b0;
   logic [7:0]  tx_wdata;
   logic        tx_wten;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [7:0]  cmd_code;
   logic [1:0]  cmd_argc;
   logic [31:0] cmd_arg0;
   logic [31:0] cmd_arg1;
   logic        parse_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rx_mem [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;

   logic [7:0] txlog [0:1023];
   int tx_cnt = 0;
   int rden_cnt = 0;
   int rden_b2b_cnt = 0;
   int rden_held_cnt = 0;
   int wten_full_cnt = 0;
   int err_cnt = 0;
   int valid_rise = 0;
   logic prev_rden = 1'b0;
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;

   assign rx_fifo_dvalid = (wr_ptr != rd_ptr);
   assign rx_rdata       = rx_mem[rd_ptr];

   mon_cmd_parser #(.ECHO_EN(1), .ARG_W(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_fifo_dvalid (rx_fifo_dvalid),
      .rx_rdata       (rx_rdata),
      .rx_rden        (rx_rden),
      .tx_fifo_full   (tx_fifo_full),
      .tx_wdata       (tx_wdata),
      .tx_wten        (tx_wten),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_code       (cmd_code),
      .cmd_argc       (cmd_argc),
      .cmd_arg0       (cmd_arg0),
      .cmd_arg1       (cmd_arg1),
      .parse_err      (parse_err)
   );

   always @(posedge clk) begin
      prev_rden  <= rx_rden;
      prev_valid <= cmd_valid;
      if (rx_rden) begin
         rd_ptr   <= rd_ptr + 1;
         rden_cnt <= rden_cnt + 1;
      end
      if (rx_rden && prev_rden) rden_b2b_cnt <= rden_b2b_cnt + 1;
      if (rx_rden && cmd_valid) rden_held_cnt <= rden_held_cnt + 1;
      if (tx_wten) begin
         txlog[tx_cnt] <= tx_wdata;
         tx_cnt <= tx_cnt + 1;
         if (tx_fifo_full) wten_full_cnt <= wten_full_cnt + 1;
      end
      if (parse_err) err_cnt <= err_cnt + 1;
      if (cmd_valid && !prev_valid) valid_rise <= valid_rise + 1;
   end

   task automatic push_byte(input logic [7:0] b);
      rx_mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) push_byte(s[i]);
   endtask

   task automatic wait_cmd(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (cmd_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic consume();
      @(negedge clk) cmd_ready = 1'b1;
      @(negedge clk) cmd_ready = 1'b0;
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (rd_ptr == wr_ptr) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] got;
      got = {cmd_valid, rx_rden, tx_wten, parse_err, cmd_argc, cmd_code};
      n_checks++;
      if (got !== 32'h0) begin
         n_fail++; $display("FAIL reset_ctrl got=%h exp=%h", got, 32'h0);
      end
      n_checks++;
      if (cmd_arg0 !== 32'h0 || cmd_arg1 !== 32'h0) begin
         n_fail++; $display("FAIL reset_args got=%h/%h exp=0/0", cmd_arg0, cmd_arg1);
      end
   endtask

   task automatic test_read_cmd();
      logic [7:0] exp_echo [8];
      int base;
      bit ok;
      exp_echo = '{8'h72, 8'h20, 8'h31, 8'h41, 8'h32, 8'h62, 8'h0D, 8'h0A};
      base = tx_cnt;
      push_str("r 1A2b"); push_byte(8'h0D);
      wait_cmd(300, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL read_timeout got=0 exp=1"); end
      n_checks++;
      if (cmd_code !== 8'h52 || cmd_argc !== 2'd1) begin
         n_fail++; $display("FAIL read_code got=%h/%0d exp=52/1", cmd_code, cmd_argc);
      end
      n_checks++;
      if (cmd_arg0 !== 32'h1A2B || cmd_arg1 !== 32'h0) begin
         n_fail++; $display("FAIL read_args got=%h/%h exp=00001a2b/0", cmd_arg0, cmd_arg1);
      end
      n_checks++;
      if (tx_cnt - base !== 8) begin
         n_fail++; $display("FAIL read_echo_count got=%0d exp=8", tx_cnt - base);
      end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (txlog[base+i] !== exp_echo[i]) begin
            n_fail++; $display("FAIL read_echo[%0d] got=%h exp=%h", i, txlog[base+i], exp_echo[i]);
         end
      end
      consume();
      n_checks++;
      if (cmd_valid !== 1'b0) begin
         n_fail++; $display("FAIL read_release got=%b exp=0", cmd_valid);
      end
   endtask

   task automatic test_hold();
      int rd0;
      int rden0;
      int drops;
      bit ok;
      drops = 0;
      push_str("w 100 DEADBEEF"); push_byte(8'h0D);
      push_str("t");
      wait_cmd(500, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL hold_timeout got=0 exp=1"); end
      rd0 = rd_ptr;
      rden0 = rden_cnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!cmd_valid || cmd_arg1 !== 32'hDEADBEEF) drops++;
      end
      n_checks++;
      if (drops !== 0) begin
         n_fail++; $display("FAIL hold_stable got=%0d exp=0", drops);
      end
      n_checks++;
      if (rden_cnt !== rden0) begin
         n_fail++; $display("FAIL hold_no_read got=%0d exp=%0d", rden_cnt, rden0);
      end
      n_checks++;
      if (cmd_argc !== 2'd2 || cmd_arg0 !== 32'h100 || cmd_arg1 !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL hold_args got=%0d/%h/%h exp=2/00000100/deadbeef",
                            cmd_argc, cmd_arg0, cmd_arg1);
      end
      consume();
      repeat (5) @(negedge clk);
      n_checks++;
      if (rd_ptr !== rd0 + 1) begin
         n_fail++; $display("FAIL hold_next_read got=%0d exp=%0d", rd_ptr, rd0 + 1);
      end
      push_byte(8'h0D);
      wait_cmd(300, ok);
      n_checks++;
      if (!ok || cmd_code !== 8'h54 || cmd_argc !== 2'd0) begin
         n_fail++; $display("FAIL hold_followup got=%b/%h/%0d exp=1/54/0", ok, cmd_code, cmd_argc);
      end
      consume();
   endtask

   task automatic test_overflow();
      bit ok;
      push_str("d 123456789"); push_byte(8'h0D);
      wait_cmd(500, ok);
      n_checks++;
      if (!ok || cmd_code !== 8'h44 || cmd_argc !== 2'd1 || cmd_arg0 !== 32'h23456789) begin
         n_fail++; $display("FAIL overflow got=%b/%h/%0d/%h exp=1/44/1/23456789",
                            ok, cmd_code, cmd_argc, cmd_arg0);
      end
      consume();
   endtask

   task automatic test_parse_err();
      int e0;
      int v0;
      bit ok;
      e0 = err_cnt;
      v0 = valid_rise;
      push_str("x 1 2 3"); push_byte(8'h0D);
      drain(ok);
      n_checks++;
      if (!ok || err_cnt - e0 !== 1) begin
         n_fail++; $display("FAIL err_pulse got=%0d exp=1", err_cnt - e0);
      end
      n_checks++;
      if (valid_rise !== v0) begin
         n_fail++; $display("FAIL err_no_cmd got=%0d exp=%0d", valid_rise, v0);
      end
   endtask

   task automatic test_esc();
      bit ok;
      push_str("r 5"); push_byte(8'h1B); push_str("g"); push_byte(8'h0D);
      wait_cmd(500, ok);
      n_checks++;
      if (!ok || cmd_code !== 8'h47 || cmd_argc !== 2'd0 || cmd_arg0 !== 32'h0) begin
         n_fail++; $display("FAIL esc got=%b/%h/%0d/%h exp=1/47/0/0", ok, cmd_code, cmd_argc, cmd_arg0);
      end
      consume();
   endtask

   task automatic test_empty();
      int e0;
      int v0;
      int base;
      bit ok;
      e0 = err_cnt;
      v0 = valid_rise;
      base = tx_cnt;
      push_byte(8'h0D);
      drain(ok);
      n_checks++;
      if (!ok || valid_rise !== v0 || err_cnt !== e0) begin
         n_fail++; $display("FAIL empty_line got=%0d/%0d exp=0/0", valid_rise - v0, err_cnt - e0);
      end
      n_checks++;
      if (tx_cnt - base !== 2 || txlog[base] !== 8'h0D || txlog[base+1] !== 8'h0A) begin
         n_fail++; $display("FAIL empty_echo got=%0d/%h/%h exp=2/0d/0a",
                            tx_cnt - base, txlog[base], txlog[base+1]);
      end
   endtask

   task automatic test_tx_stall();
      logic [7:0] exp_echo [5];
      int base;
      int r0;
      int t0;
      bit ok;
      exp_echo = '{8'h71, 8'h20, 8'h37, 8'h0D, 8'h0A};
      base = tx_cnt;
      push_str("q 7"); push_byte(8'h0D);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_cnt - base >= 2) begin ok = 1'b1; break; end
      end
      tx_fifo_full = 1'b1;
      repeat (5) @(negedge clk);
      r0 = rden_cnt;
      t0 = tx_cnt;
      repeat (50) @(negedge clk);
      n_checks++;
      if (!ok || rden_cnt !== r0 || tx_cnt !== t0) begin
         n_fail++; $display("FAIL stall_frozen got=%b/%0d/%0d exp=1/0/0", ok, rden_cnt - r0, tx_cnt - t0);
      end
      tx_fifo_full = 1'b0;
      wait_cmd(300, ok);
      n_checks++;
      if (!ok || cmd_code !== 8'h51 || cmd_arg0 !== 32'h7) begin
         n_fail++; $display("FAIL stall_cmd got=%b/%h/%h exp=1/51/7", ok, cmd_code, cmd_arg0);
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (txlog[base+i] !== exp_echo[i]) begin
            n_fail++; $display("FAIL stall_echo[%0d] got=%h exp=%h", i, txlog[base+i], exp_echo[i]);
         end
      end
      consume();
   endtask

   task automatic test_reset_exec();
      bit ok;
      push_str("z"); push_byte(8'h0D);
      wait_cmd(300, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rexec_timeout got=0 exp=1"); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (cmd_valid !== 1'b0 || cmd_code !== 8'h0) begin
         n_fail++; $display("FAIL rexec_cleared got=%b/%h exp=0/00", cmd_valid, cmd_code);
      end
      @(negedge clk) rst_n = 1'b1;
      push_str("r 3"); push_byte(8'h0D);
      wait_cmd(300, ok);
      n_checks++;
      if (!ok || cmd_code !== 8'h52 || cmd_argc !== 2'd1 || cmd_arg0 !== 32'h3) begin
         n_fail++; $display("FAIL rexec_after got=%b/%h/%0d/%h exp=1/52/1/3",
                            ok, cmd_code, cmd_argc, cmd_arg0);
      end
      consume();
   endtask

   task automatic test_protocol();
      n_checks++;
      if (rden_b2b_cnt !== 0) begin
         n_fail++; $display("FAIL rden_spacing got=%0d exp=0", rden_b2b_cnt);
      end
      n_checks++;
      if (rden_held_cnt !== 0) begin
         n_fail++; $display("FAIL rden_while_valid got=%0d exp=0", rden_held_cnt);
      end
      n_checks++;
      if (wten_full_cnt !== 0) begin
         n_fail++; $display("FAIL wten_while_full got=%0d exp=0", wten_full_cnt);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_read_cmd();
      test_hold();
      test_overflow();
      test_parse_err();
      test_esc();
      test_empty();
      test_tx_stall();
      test_reset_exec();
      test_protocol();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
